alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand and result width.
REQ-002 SHALL have parameter NUNITS, default 6, number of functional-unit enables.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req_valid  input  2  and req_ready  output  2, one bit per requester (0, 1).
REQ-006 SHALL have ports req0_op and req1_op  input  3  opcode, plus req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
REQ-007 SHALL have port unit_en  output  NUNITS  one-hot functional-unit enable: bit 0 AND, 1 OR, 2 XOR, 3 NOT-A, 4 ADD, 5 SUB.
REQ-008 SHALL have ports unit_a and unit_b  output  WIDTH  operands broadcast to all units.
REQ-009 SHALL have port unit_res  input  WIDTH  result from the enabled unit.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1, rsp_data  output  WIDTH, rsp_err  output  1.

Function
REQ-011 SHALL implement FSM IDLE -> EXEC -> HOLD -> IDLE.
REQ-012 IDLE: a request is accepted when req_valid[i] & req_ready[i]; req_ready is high only in IDLE, only for the granted requester, at most one bit high.
REQ-013 Arbitration: single valid requester wins; both valid -> requester not granted last wins; priority pointer resets to favour requester 0.
REQ-014 Accept cycle SHALL register opcode, operands, id and update the priority pointer; next state EXEC.
REQ-015 EXEC (exactly one cycle): drive unit_en one-hot per opcode, unit_a/unit_b from registered operands; capture unit_res into rsp_data at the end of the cycle; next state HOLD.
REQ-016 Outside EXEC, unit_en SHALL be all zeros; unit_a/unit_b hold last values; unit_res SHALL be ignored (disabled units drive X).
REQ-017 Opcodes 110/111 illegal: unit_en stays zero in EXEC, rsp_data = 0, rsp_err = 1; legal ops give rsp_err = 0.
REQ-018 HOLD: rsp_valid = 1 with rsp_id/rsp_data/rsp_err stable until rsp_ready = 1; that cycle completes the transfer, next state IDLE.
REQ-019 Latency: accept at cycle N, unit enabled at N+1, rsp_valid first high at N+2; minimum 3 cycles per operation.
REQ-020 Request arriving during EXEC/HOLD SHALL wait (req_ready low); requesters must hold valid and payload stable until accepted.
REQ-021 rsp_ready high outside HOLD SHALL have no effect.

Reset
REQ-022 rst SHALL asynchronously force IDLE, unit_en = 0, unit_a = unit_b = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, rsp_id = 0, priority pointer to requester 0.
REQ-023 Reset during EXEC or HOLD SHALL discard the in-flight operation; no response is produced after reset release.
REQ-024 First acceptance possible on the first rising edge after rst deasserts.

Structure
REQ-025 Opcode encodings, unit-enable bit indices and FSM state encodings SHALL live in shared package alu_pkg.
REQ-026 Round-robin grant logic SHALL be sub-module rr_arb2 (2-input, pointer register inside); decode and FSM stay in alu_arbiter.

Verification
REQ-027 Single op: req0 op=001 a=4'b1010 b=4'b0101 -> accept N, unit_en=6'b000010 at N+1, rsp_valid N+2, rsp_data=4'b1111, rsp_id=0, rsp_err=0.
REQ-028 Contention: both valid from reset, held -> grants 0,1,0,1 alternate; req_ready never two-hot.
REQ-029 Backpressure: rsp_ready low 5 cycles in HOLD -> rsp_valid high, rsp_data stable all 5 cycles; req_ready low throughout; completes on first rsp_ready.
REQ-030 Illegal op: req1 op=111 -> unit_en stays 0 for the whole operation, rsp_data=0, rsp_err=1, rsp_id=1.
REQ-031 Reset mid-op: assert rst during EXEC -> unit_en and rsp_valid 0 immediately (asynchronously); no rsp_valid after release until a new accept.
REQ-032 X isolation: unit_res driven X outside EXEC, valid 4'h6 in EXEC -> rsp_data = 4'h6, never X.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, functional-unit index and FSM state definitions for the ALU arbiter.
// Each opcode value equals the bit index of the unit it enables.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOTA = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101
  } alu_op_e;

  localparam int U_AND  = 0;
  localparam int U_OR   = 1;
  localparam int U_XOR  = 2;
  localparam int U_NOTA = 3;
  localparam int U_ADD  = 4;
  localparam int U_SUB  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } alu_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_SUB);
  endfunction

  function automatic int op_unit(input logic [2:0] op);
    case (op)
      OP_AND:  return U_AND;
      OP_OR:   return U_OR;
      OP_XOR:  return U_XOR;
      OP_NOTA: return U_NOTA;
      OP_ADD:  return U_ADD;
      OP_SUB:  return U_SUB;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational from req_i and the pointer.
// The pointer moves to favour the other requester only when upd_i marks a taken grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // After serving requester 0, favour 1 next time, and vice versa.
  always_comb begin
    prio_d = prio_q;
    if (upd_i) prio_d = gnt_o[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto shared ALU units: accept, one EXEC cycle, then HOLD
// until rsp_ready; response appears two cycles after accept and stalls under backpressure.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NUNITS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2:0]        req0_op,
  input  logic [2:0]        req1_op,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  output logic [NUNITS-1:0] unit_en,
  output logic [WIDTH-1:0]  unit_a,
  output logic [WIDTH-1:0]  unit_b,
  input  logic [WIDTH-1:0]  unit_res,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err
);

  alu_state_e       state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic             rsp_id_q, rsp_err_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [1:0]       gnt;
  logic             accept;
  logic             exec_ok;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_valid),
    .upd_i (accept),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = gnt;
        accept    = |(req_valid & gnt);
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_HOLD;
      ST_HOLD: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Illegal opcodes, or units beyond NUNITS, leave every enable low.
  always_comb begin
    exec_ok = op_legal(op_q) && (op_unit(op_q) < NUNITS);
    unit_en = '0;
    if (state_q == ST_EXEC && exec_ok) begin
      for (int u = 0; u < NUNITS; u++) begin
        if (u == op_unit(op_q)) unit_en[u] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= 3'b000;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q <= gnt[1];
        op_q <= gnt[1] ? req1_op : req0_op;
        a_q  <= gnt[1] ? req1_a  : req0_a;
        b_q  <= gnt[1] ? req1_b  : req0_b;
      end
      // unit_res is only trusted while a legal unit is enabled.
      if (state_q == ST_EXEC) begin
        rsp_id_q   <= id_q;
        rsp_data_q <= exec_ok ? unit_res : '0;
        rsp_err_q  <= !exec_ok;
      end
    end
  end

  assign unit_a    = a_q;
  assign unit_b    = b_q;
  assign rsp_valid = (state_q == ST_HOLD);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single operations plus contention,
// backpressure, reset-mid-op and X-isolation sequences.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0] unit_en;
  logic [3:0] unit_a, unit_b, unit_res;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [3:0] rsp_data;
  logic       x_mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(4), .NUNITS(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .unit_en(unit_en), .unit_a(unit_a), .unit_b(unit_b), .unit_res(unit_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Functional units: X whenever nothing is enabled.
  always_comb begin
    unit_res = 'x;
    if (x_mode) begin
      if (|unit_en) unit_res = 4'h6;
    end else begin
      case (unit_en)
        6'b000001: unit_res = unit_a & unit_b;
        6'b000010: unit_res = unit_a | unit_b;
        6'b000100: unit_res = unit_a ^ unit_b;
        6'b001000: unit_res = ~unit_a;
        6'b010000: unit_res = unit_a + unit_b;
        6'b100000: unit_res = unit_a - unit_b;
        default:   unit_res = 'x;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [5:0] en;
    logic [3:0] data;
    logic       err;
  } vec_t;

  vec_t vec [8];
  logic [1:0] exp_gnt [4];

  initial begin
    vec[0] = '{1'b0, 3'b001, 4'b1010, 4'b0101, 6'b000010, 4'b1111, 1'b0};
    vec[1] = '{1'b0, 3'b000, 4'b1100, 4'b1010, 6'b000001, 4'b1000, 1'b0};
    vec[2] = '{1'b1, 3'b010, 4'b1100, 4'b1010, 6'b000100, 4'b0110, 1'b0};
    vec[3] = '{1'b0, 3'b011, 4'b0011, 4'b0000, 6'b001000, 4'b1100, 1'b0};
    vec[4] = '{1'b1, 3'b100, 4'b1001, 4'b1000, 6'b010000, 4'b0001, 1'b0};
    vec[5] = '{1'b0, 3'b101, 4'b0010, 4'b0101, 6'b100000, 4'b1101, 1'b0};
    vec[6] = '{1'b1, 3'b111, 4'b1111, 4'b1111, 6'b000000, 4'b0000, 1'b1};
    vec[7] = '{1'b0, 3'b110, 4'b0110, 4'b0011, 6'b000000, 4'b0000, 1'b1};
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;

    rst = 1'b1; x_mode = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    req0_op = 3'b000; req1_op = 3'b000;
    req0_a = 4'h0; req0_b = 4'h0; req1_a = 4'h0; req1_b = 4'h0;
    repeat (3) step();
    chk("rst_unit_en", unit_en, 6'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 4'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_unit_a", unit_a, 4'h0);
    chk("rst_unit_b", unit_b, 4'h0);
    chk("rst_req_ready", req_ready, 2'b00);
    rst = 1'b0;

    // Table of single operations: accept N, enable N+1, response N+2.
    for (int i = 0; i < 8; i++) begin
      if (vec[i].id) begin
        req1_op = vec[i].op; req1_a = vec[i].a; req1_b = vec[i].b; req_valid = 2'b10;
      end else begin
        req0_op = vec[i].op; req0_a = vec[i].a; req0_b = vec[i].b; req_valid = 2'b01;
      end
      #1;
      chk("idle_ready", req_ready, vec[i].id ? 2'b10 : 2'b01);
      chk("idle_en", unit_en, 6'b0);
      step();
      req_valid = 2'b00;
      chk("exec_en", unit_en, vec[i].en);
      chk("exec_a", unit_a, vec[i].a);
      chk("exec_b", unit_b, vec[i].b);
      chk("exec_rsp_valid", rsp_valid, 1'b0);
      step();
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rsp_data", rsp_data, vec[i].data);
      chk("hold_rsp_err", rsp_err, vec[i].err);
      chk("hold_rsp_id", rsp_id, vec[i].id);
      chk("hold_en", unit_en, 6'b0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("done_rsp_valid", rsp_valid, 1'b0);
    end

    // Contention from a fresh reset: grants alternate starting with requester 0.
    rst = 1'b1; #2; rst = 1'b0;
    req0_op = 3'b000; req0_a = 4'hF; req0_b = 4'h3;
    req1_op = 3'b001; req1_a = 4'h8; req1_b = 4'h1;
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_ready", req_ready, exp_gnt[k]);
      step();
      chk("cont_exec_ready", req_ready, 2'b00);
      step();
      chk("cont_hold_id", rsp_id, exp_gnt[k][1]);
      chk("cont_hold_data", rsp_data, exp_gnt[k][1] ? 4'h9 : 4'h3);
      chk("cont_hold_ready", req_ready, 2'b00);
      step();
    end
    req_valid = 2'b00; rsp_ready = 1'b0;

    // Backpressure: five stalled HOLD cycles while requester 1 waits.
    req0_op = 3'b100; req0_a = 4'h3; req0_b = 4'h4; req_valid = 2'b01;
    #1;
    chk("bp_ready", req_ready, 2'b01);
    step();
    req1_op = 3'b010; req1_a = 4'hF; req1_b = 4'h5; req_valid = 2'b10;
    #1;
    chk("bp_exec_ready", req_ready, 2'b00);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_data", rsp_data, 4'h7);
      chk("bp_hold_ready", req_ready, 2'b00);
      step();
    end
    chk("bp_still_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_done_valid", rsp_valid, 1'b0);
    chk("bp_waiter_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    step();
    chk("bp_second_data", rsp_data, 4'hA);
    chk("bp_second_id", rsp_id, 1'b1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset asserted mid-EXEC clears outputs asynchronously and drops the op.
    req0_op = 3'b001; req0_a = 4'h5; req0_b = 4'h2; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    chk("rmid_exec_en", unit_en, 6'b000010);
    #2 rst = 1'b1;
    #1;
    chk("rmid_async_en", unit_en, 6'b0);
    chk("rmid_async_valid", rsp_valid, 1'b0);
    step();
    rst = 1'b0;
    chk("rmid_rsp_data", rsp_data, 4'h0);
    chk("rmid_unit_a", unit_a, 4'h0);
    for (int k = 0; k < 4; k++) begin
      chk("rmid_no_rsp", rsp_valid, 1'b0);
      step();
    end

    // X isolation; rsp_ready held high outside HOLD must not skip the response.
    x_mode = 1'b1;
    req1_op = 3'b000; req1_a = 4'h9; req1_b = 4'h3; req_valid = 2'b10; rsp_ready = 1'b1;
    step();
    req_valid = 2'b00;
    chk("xiso_exec_en", unit_en, 6'b000001);
    step();
    chk("xiso_hold_valid", rsp_valid, 1'b1);
    chk("xiso_hold_data", rsp_data, 4'h6);
    step();
    rsp_ready = 1'b0;
    chk("xiso_done_valid", rsp_valid, 1'b0);
    chk("xiso_data_kept", rsp_data, 4'h6);
    x_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
